// File: rtl/ex_memunit.sv
// ex_memunit: load/store execution unit.
// Accepts one memory op per issue from the scheduler, runs a single
// data-memory bus transaction and returns the result to commit on the
// out/rd_out_rn/valid/stall channel. Stores complete through commit with
// rd_out_rn=0. A bus request that waits WAIT_LIMIT cycles without a response
// completes with fault=1 (WAIT_LIMIT=0 disables the timeout).
//
// Build option: define MEMUNIT_ALIGN_CHECK_EN to trap misaligned accesses at
// issue (64-bit with ea[2:0]!=0, 32-bit with ea[1:0]!=0). Such ops skip the
// bus entirely and complete with fault=1. Without the macro the low address
// bits below the 32-bit lane select are ignored.

module ex_memunit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  input  logic [31:0] imm,
  input  logic        ex_enable,
  output logic        ex_busy,
  input  logic [5:0]  rd_in_rn,
  input  logic [1:0]  op,
  output logic [5:0]  rd_out_rn,
  output logic [63:0] out,
  output logic        valid,
  input  logic        stall,
  output logic        fault,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  output logic        dmem_we,
  output logic        dmem_addr_valid,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_data_valid
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Timeout limit folded to the counter width; 0 disables the timeout.
  localparam logic [15:0] WAIT_LIMIT_W = 16'(WAIT_LIMIT);
  localparam bit          TIMEOUT_EN   = (WAIT_LIMIT != 0);

  // op field decode
  localparam int OP_STORE_BIT = 1;
  localparam int OP_WORD_BIT  = 0;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]  state_q,     state_d;
  logic [63:2] ea_q,        ea_d;        // effective address, byte-in-word bits dropped
  logic [1:0]  op_q,        op_d;
  logic [5:0]  rd_q,        rd_d;        // destination captured at issue
  logic [63:0] st_data_q,   st_data_d;   // rs2 data captured at issue
  logic [15:0] cnt_q,       cnt_d;       // REQ cycle counter for the timeout
  logic [63:0] out_q,       out_d;
  logic [5:0]  rd_out_q,    rd_out_d;
  logic        fault_q,     fault_d;

  // --------------------------------------------------------------------------
  // Issue-time address generation
  // --------------------------------------------------------------------------
  logic [63:0] imm_sext;
  logic [63:0] ea_issue;
  logic        misaligned_issue;

  // Effective address of the op being offered by the scheduler.
  always_comb begin
    imm_sext = {{32{imm[31]}}, imm};
    ea_issue = in1 + imm_sext;
  end

`ifdef MEMUNIT_ALIGN_CHECK_EN
  // A 32-bit access needs 4-byte alignment, a 64-bit access 8-byte alignment.
  assign misaligned_issue = op[OP_WORD_BIT] ? (ea_issue[1:0] != 2'b00)
                                            : (ea_issue[2:0] != 3'b000);
`else
  // Low address bits are deliberately ignored in this build.
  logic unused_ea_low;
  assign unused_ea_low    = ^ea_issue[1:0];
  assign misaligned_issue = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Load data extraction
  // --------------------------------------------------------------------------
  logic [31:0] load_word;
  logic [63:0] load_result;
  logic [15:0] cnt_inc;
  logic        timeout_hit;

  // Pick the addressed 32-bit lane and sign-extend it for word loads.
  always_comb begin
    load_word   = ea_q[2] ? dmem_rdata[63:32] : dmem_rdata[31:0];
    load_result = op_q[OP_WORD_BIT] ? {{32{load_word[31]}}, load_word}
                                    : dmem_rdata;
    cnt_inc     = cnt_q + 16'd1;
    timeout_hit = TIMEOUT_EN && (cnt_inc == WAIT_LIMIT_W);
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // Sequences IDLE -> REQ -> DONE (or IDLE -> DONE for a trapped op).
  always_comb begin
    // NOTE: every _d starts as its _q so unassigned paths hold state rather
    // than inferring latches.
    state_d   = state_q;
    ea_d      = ea_q;
    op_d      = op_q;
    rd_d      = rd_q;
    st_data_d = st_data_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    rd_out_d  = rd_out_q;
    fault_d   = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (ex_enable) begin
          ea_d      = ea_issue[63:2];
          op_d      = op;
          rd_d      = rd_in_rn;
          st_data_d = in2;
          cnt_d     = 16'd0;
          if (misaligned_issue) begin
            // Trapped at issue: no bus activity, straight to commit.
            state_d  = ST_DONE;
            out_d    = 64'd0;
            rd_out_d = 6'd0;
            fault_d  = 1'b1;
          end else begin
            state_d  = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        cnt_d = cnt_inc;
        // A response on the limit edge wins over the timeout.
        if (dmem_data_valid) begin
          state_d = ST_DONE;
          fault_d = 1'b0;
          if (op_q[OP_STORE_BIT]) begin
            out_d    = 64'd0;
            rd_out_d = 6'd0;
          end else begin
            out_d    = load_result;
            rd_out_d = rd_q;
          end
        end else if (timeout_hit) begin
          state_d  = ST_DONE;
          out_d    = 64'd0;
          rd_out_d = 6'd0;
          fault_d  = 1'b1;
        end
      end

      ST_DONE: begin
        // Result is held until commit takes it.
        if (!stall) begin
          state_d  = ST_IDLE;
          rd_out_d = 6'd0;
          fault_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ea_q      <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      st_data_q <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      rd_out_q  <= '0;
      fault_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q   <= state_d;
      ea_q      <= ea_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      st_data_q <= st_data_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      rd_out_q  <= rd_out_d;
      fault_q   <= fault_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  logic in_req;
  logic [7:0]  be_word;
  logic [63:0] wdata_req;

  // Bus request fields, driven only while in REQ so they read 0 otherwise.
  always_comb begin
    in_req    = (state_q == ST_REQ);
    be_word   = ea_q[2] ? 8'hF0 : 8'h0F;
    wdata_req = op_q[OP_WORD_BIT] ? {st_data_q[31:0], st_data_q[31:0]}
                                  : st_data_q;

    dmem_addr_valid = in_req;
    dmem_addr       = in_req ? {ea_q[63:3], 3'b000} : 64'd0;
    dmem_we         = in_req & op_q[OP_STORE_BIT];
    dmem_be         = in_req ? (op_q[OP_WORD_BIT] ? be_word : 8'hFF) : 8'h00;
    dmem_wdata      = in_req ? wdata_req : 64'd0;
  end

  assign ex_busy   = (state_q != ST_IDLE);
  assign valid     = (state_q == ST_DONE);
  assign out       = out_q;
  assign rd_out_rn = rd_out_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_ex_memunit.sv
// tb_ex_memunit: scoreboard bench for ex_memunit.
// Issue side pushes expected bus requests and expected commit results; a bus
// responder and a commit monitor pop and compare independently.

module tb_ex_memunit;

  localparam int W = 4;  // WAIT_LIMIT used for the DUT

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] in1 = '0;
  logic [63:0] in2 = '0;
  logic [31:0] imm = '0;
  logic        ex_enable = 1'b0;
  logic        ex_busy;
  logic [5:0]  rd_in_rn = '0;
  logic [1:0]  op = '0;
  logic [5:0]  rd_out_rn;
  logic [63:0] out;
  logic        valid;
  logic        stall;
  logic        fault;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_be;
  logic        dmem_we;
  logic        dmem_addr_valid;
  logic [63:0] dmem_rdata;
  logic        dmem_data_valid;

  always #5 clk = ~clk;

  ex_memunit #(.WAIT_LIMIT(W)) dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .imm(imm),
    .ex_enable(ex_enable), .ex_busy(ex_busy), .rd_in_rn(rd_in_rn), .op(op),
    .rd_out_rn(rd_out_rn), .out(out), .valid(valid), .stall(stall),
    .fault(fault), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_we(dmem_we), .dmem_addr_valid(dmem_addr_valid),
    .dmem_rdata(dmem_rdata), .dmem_data_valid(dmem_data_valid)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  be;
    logic        we;
    logic [63:0] wdata;
    int          lat;    // cycles in REQ before data_valid; 0 = never respond
    logic [63:0] rdata;
  } bus_job_t;

  typedef struct {
    logic [63:0] out;
    logic [5:0]  rd;
    logic        fault;
    int          delta;      // cycles from issue edge to first valid cycle
    int          issue_cyc;
  } exp_t;

  bus_job_t bus_q[$];
  exp_t     exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit stall_force = 1'b1;
  bit stall_val = 1'b0;
  int stall_pct = 30;
  bit checked = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: derives bus request and commit result from the op.
  function automatic void model(input logic [1:0] op_i, input logic [63:0] a,
                                input logic [63:0] d, input logic [31:0] im,
                                input logic [5:0] rd, input int lat,
                                input logic [63:0] rdata,
                                output exp_t e, output bit has_bus,
                                output bus_job_t j);
    logic [63:0] ea;
    logic [63:0] word;
    int nbytes;
    bit mis;
    bit timed_out;
    ea = a + {{32{im[31]}}, im};
    nbytes = op_i[0] ? 4 : 8;
    mis = 1'b0;
`ifdef MEMUNIT_ALIGN_CHECK_EN
    mis = (ea % nbytes) != 0;
`endif
    j.addr  = ea - (ea % 8);
    j.be    = op_i[0] ? (8'h0F << (ea[2] ? 4 : 0)) : 8'hFF;
    j.we    = op_i[1];
    j.wdata = op_i[0] ? {d[31:0], d[31:0]} : d;
    j.lat   = lat;
    j.rdata = rdata;
    has_bus = !mis;
    timed_out = (lat == 0) || (lat > W);
    if (mis) begin
      e.out = 0; e.rd = 0; e.fault = 1'b1; e.delta = 0;
    end else if (timed_out) begin
      e.out = 0; e.rd = 0; e.fault = 1'b1; e.delta = W;
    end else begin
      e.delta = lat;
      e.fault = 1'b0;
      if (op_i[1]) begin
        e.out = 0; e.rd = 0;
      end else begin
        e.rd = rd;
        if (op_i[0]) begin
          word = rdata >> (ea[2] ? 32 : 0);
          e.out = {{32{word[31]}}, word[31:0]};
        end else begin
          e.out = rdata;
        end
      end
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Commit backpressure driver.
  initial begin
    stall = 1'b0;
    forever begin
      @(negedge clk);
      stall = stall_force ? stall_val : ($urandom_range(0, 99) < stall_pct);
    end
  end

  // Handshake tracker: a result leaves DONE on an edge with stall low.
  initial forever begin
    @(posedge clk);
    if (!rst_n || (valid && !stall)) checked = 1'b0;
  end

  // Commit monitor.
  initial begin
    exp_t cur;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (rst_n && valid) begin
        if (!checked) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_valid: got valid=1 expected no result pending");
            cur.out = out; cur.rd = rd_out_rn; cur.fault = fault;
          end else begin
            cur = exp_q.pop_front();
            check("out", out, cur.out);
            check("rd_out_rn", 64'(rd_out_rn), 64'(cur.rd));
            check("fault", 64'(fault), 64'(cur.fault));
            check("latency", 64'(cyc - cur.issue_cyc), 64'(cur.delta));
          end
          checked = 1'b1;
        end else begin
          check("hold_out", out, cur.out);
          check("hold_rd", 64'(rd_out_rn), 64'(cur.rd));
          check("hold_fault", 64'(fault), 64'(cur.fault));
        end
        check("busy_in_done", 64'(ex_busy), 64'd1);
      end
    end
  end

  // Bus responder: checks request fields every REQ cycle and answers after lat.
  initial begin
    bus_job_t cur;
    bit active;
    bit known;
    int seen;
    active = 1'b0; known = 1'b0; seen = 0;
    cur = '{default: 0};
    dmem_data_valid = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !dmem_addr_valid) begin
        active = 1'b0;
        dmem_data_valid = 1'b0;
        dmem_rdata = {$urandom, $urandom};
      end else begin
        if (!active) begin
          active = 1'b1;
          seen = 0;
          if (bus_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_request: got addr=%h expected no request", dmem_addr);
            known = 1'b0;
            cur.lat = 1;
          end else begin
            cur = bus_q.pop_front();
            known = 1'b1;
          end
        end
        seen++;
        if (known) begin
          check("dmem_addr", dmem_addr, cur.addr);
          check("dmem_be", 64'(dmem_be), 64'(cur.be));
          check("dmem_we", 64'(dmem_we), 64'(cur.we));
          check("dmem_wdata", dmem_wdata, cur.wdata);
          check("busy_in_req", 64'(ex_busy), 64'd1);
        end
        dmem_data_valid = (cur.lat != 0) && (seen == cur.lat);
        dmem_rdata = dmem_data_valid ? cur.rdata : {$urandom, $urandom};
      end
    end
  end

  // Issue one op once the unit is idle; garbage issue while busy must be ignored.
  task automatic issue(input logic [1:0] op_i, input logic [63:0] a,
                       input logic [63:0] d, input logic [31:0] im,
                       input logic [5:0] rd, input int lat,
                       input logic [63:0] rdata);
    exp_t e;
    bus_job_t j;
    bit has_bus;
    int n;
    n = 0;
    @(negedge clk);
    while (ex_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ex_busy) begin
      tests++; fails++;
      $display("FAIL issue_wait: got ex_busy=1 expected 0 within 100 cycles");
      return;
    end
    model(op_i, a, d, im, rd, lat, rdata, e, has_bus, j);
    e.issue_cyc = cyc + 1;
    exp_q.push_back(e);
    if (has_bus) bus_q.push_back(j);
    op = op_i; in1 = a; in2 = d; imm = im; rd_in_rn = rd;
    ex_enable = 1'b1;
    @(negedge clk);
    op = 2'($urandom); in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom};
    imm = $urandom; rd_in_rn = 6'($urandom);
    @(posedge clk);
    #1 ex_enable = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((ex_busy || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(ex_busy || exp_q.size() != 0), 64'd0);
  endtask

  initial begin
    int n;
    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(ex_busy), 0);
    check("rst_valid", 64'(valid), 0);
    check("rst_fault", 64'(fault), 0);
    check("rst_rd", 64'(rd_out_rn), 0);
    check("rst_out", out, 0);
    check("rst_addr_valid", 64'(dmem_addr_valid), 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_we", 64'(dmem_we), 0);
    check("rst_be", 64'(dmem_be), 0);
    check("rst_wdata", dmem_wdata, 0);
    rst_n = 1'b1;

    // Directed cases
    issue(2'b00, 64'h1000, 64'h0, 32'h10, 6'd5, 1, 64'hDEADBEEF_CAFEF00D);
    issue(2'b01, 64'h2000, 64'h0, 32'h4, 6'd7, 1, 64'h80000001_12345678);
    issue(2'b01, 64'h2000, 64'h0, 32'h0, 6'd8, 1, 64'h80000001_12345678);
    issue(2'b11, 64'h3000, 64'hAABBCCDD, 32'hFFFF_FFFC, 6'd9, 1, 64'h0);
    issue(2'b00, 64'h4000, 64'h0, 32'h8, 6'd10, W, 64'h0123_4567_89AB_CDEF);
    wait_idle("directed_drain");

    // Commit backpressure
    stall_val = 1'b1;
    issue(2'b00, 64'h5000, 64'h0, 32'h0, 6'd11, 2, 64'h5555_AAAA_1234_8765);
    n = 0;
    while (!valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", 64'(valid), 1);
    repeat (3) @(negedge clk);
    check("bp_valid_held", 64'(valid), 1);
    check("bp_busy_held", 64'(ex_busy), 1);
    @(posedge clk);
    #1 stall_val = 1'b0;
    @(posedge clk);
    #1;
    check("bp_busy_released", 64'(ex_busy), 0);
    check("bp_valid_released", 64'(valid), 0);
    check("bp_rd_cleared", 64'(rd_out_rn), 0);

    // Timeout: bus never answers
    issue(2'b00, 64'h6000, 64'h0, 32'h0, 6'd12, 0, 64'h0);
    wait_idle("timeout_drain");

    // Reset in the middle of a request
    issue(2'b10, 64'h7000, 64'h1111, 32'h0, 6'd13, 0, 64'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_addr_valid", 64'(dmem_addr_valid), 0);
    check("midrst_busy", 64'(ex_busy), 0);
    check("midrst_valid", 64'(valid), 0);
    exp_q.delete();
    bus_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Misaligned 64-bit load (trapped only when the align check is built in)
    issue(2'b00, 64'h1000, 64'h0, 32'h4, 6'd3, 1, 64'hFEED_FACE_0BAD_BEEF);
    wait_idle("align_drain");

    // Randomized traffic with random backpressure
    stall_force = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic [63:0] a;
      logic [31:0] im;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
      im = 32'($urandom_range(0, 511)) - 32'd256;
      if ($urandom_range(0, 3) != 0) im[1:0] = 2'b00;
      if (i == 100) stall_pct = 60;
      issue(2'($urandom), a, {$urandom, $urandom}, im, 6'($urandom),
            int'($urandom_range(0, 6)), {$urandom, $urandom});
    end
    wait_idle("random_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_memunit.md
Name: ex_memunit

Overview:
- Load/store execution unit; sits beside ex_alu between the schedule stage and commit.
- Accepts one memory op per issue from the scheduler and performs a single data-memory bus transaction.
- Returns load data to commit on the memunit_result/rn/valid/stall channel.
- Stores also complete through commit, with rd_out_rn=0 so commit performs no register write.

Parameters:
- WAIT_LIMIT, 255: maximum cycles in REQ before a bus timeout; 0 disables the timeout. Valid range 0..65535.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in1  input  64  base address (rs1 data)
- in2  input  64  store data (rs2 data)
- imm  input  32  signed address offset
- ex_enable  input  1  issue strobe from scheduler
- ex_busy  output  1  unit cannot accept an issue
- rd_in_rn  input  6  destination register of the issued op
- op  input  2  op[1]: 1=store, 0=load; op[0]: 1=32-bit, 0=64-bit
- rd_out_rn  output  6  destination to commit; 0 = no write
- out  output  64  load result
- valid  output  1  result presented to commit
- stall  input  1  commit cannot take the result this cycle
- fault  output  1  misaligned access or bus timeout on the current result
- dmem_addr  output  64  data bus address, 8-byte aligned
- dmem_wdata  output  64  store data
- dmem_be  output  8  byte enables, little-endian
- dmem_we  output  1  1=write
- dmem_addr_valid  output  1  request valid
- dmem_rdata  input  64  read data
- dmem_data_valid  input  1  transaction complete

Behaviour:
- States: IDLE, REQ, DONE. ex_busy = (state != IDLE).
- Reset (asynchronous, immediate including mid-transaction):
  - state=IDLE.
  - All outputs 0: ex_busy, valid, fault, rd_out_rn, out, dmem_* outputs.
  - Timeout counter cleared.
- IDLE: on an edge with ex_enable=1, capture the following, then go to REQ:
  - ea = in1 + sign_extend(imm), 64-bit wrap-around.
  - op, rd_in_rn, in2.
- ex_enable while busy is ignored (scheduler contract violation, no effect).
- Bus request (REQ):
  - dmem_addr_valid=1; dmem_addr = {ea[63:3],3'b000}.
  - dmem_we=op[1].
  - 64-bit access: dmem_be=8'hFF, wdata=in2.
  - 32-bit access: dmem_be = ea[2] ? 8'hF0 : 8'h0F; wdata = {in2[31:0],in2[31:0]}.
  - All request signals held stable until dmem_data_valid is sampled high.
- Completion: on an edge in REQ with dmem_data_valid=1, go to DONE and register the result:
  - 64-bit load: out=dmem_rdata.
  - 32-bit load: out = sign-extended ea[2] ? rdata[63:32] : rdata[31:0].
  - Loads: rd_out_rn=captured rd.
  - Store: out=0, rd_out_rn=0.
  - dmem_addr_valid drops in DONE.
- Timeout counter:
  - 16-bit; cleared on entry to REQ; increments each REQ cycle.
  - When WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT without data_valid: go to DONE with fault=1, out=0, rd_out_rn=0.
  - data_valid on the same edge as the limit is reached takes priority: normal completion.
- DONE: valid=1, with out/rd_out_rn/fault held. On an edge with stall=0, go to IDLE and clear valid, fault and rd_out_rn. With stall=1, remain in DONE with all values held.
- Latency: issue edge E → addr_valid during cycle E+1. If data_valid arrives in that cycle, valid is high in cycle E+2. Back-to-back throughput is 1 op per 3 cycles minimum.

Optional Feature:
- Macro: MEMUNIT_ALIGN_CHECK_EN.
- Defined:
  - Misaligned op is detected in IDLE at issue: 64-bit with ea[2:0]!=0, or 32-bit with ea[1:0]!=0.
  - It skips REQ entirely and goes directly to DONE with fault=1, out=0, rd_out_rn=0, no bus activity.
- Undefined:
  - No alignment check; low address bits beyond ea[2] are ignored.
  - fault asserts only on timeout.

Test Plan:
- 64-bit load: in1=0x1000, imm=0x10, rd=5; bus returns 0xDEADBEEF_CAFEF00D one cycle after addr_valid → dmem_addr=0x1010, be=0xFF, we=0; valid with out=0xDEADBEEFCAFEF00D, rd_out_rn=5.
- 32-bit load, upper word: in1=0x2000, imm=4, rdata=0x80000001_12345678 → out=0xFFFFFFFF80000001; with imm=0, out=0x0000000012345678.
- 32-bit store: in1=0x3000, imm=-4, in2=0xAABBCCDD → dmem_addr=0x2FF8, be=0xF0, wdata=0xAABBCCDD_AABBCCDD, we=1; completion valid with rd_out_rn=0.
- Commit backpressure: hold stall=1 for 3 cycles in DONE → out/rd_out_rn/valid stable and ex_busy=1; state goes to IDLE on the first edge with stall=0.
- Timeout: WAIT_LIMIT=4, data_valid never asserted → fault=1, valid=1, rd_out_rn=0 after 4 REQ cycles. Repeat with rst_n pulsed low mid-REQ → dmem_addr_valid drops immediately and ex_busy=0.
- With MEMUNIT_ALIGN_CHECK_EN: 64-bit load at ea=0x1004 → no dmem_addr_valid, fault=1, valid the cycle after issue. Without the macro: same op issues dmem_addr=0x1000.
